multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multicycle ARM-like CPU. Sequences one shared ALU, one unified memory and the register file.
//  Decodes Op/Funct/Rd per state, evaluates the condition field against the internal NZCV register, and gates every write enable with CondEx.
//  Sits between the instruction register (IR) and the datapath muxes and enables.
// PARAMETERS
//  STATE_W  4  state register width (10 states used)
//  FLAG_W   4  flag register width, NZCV order [3:0]=N,Z,C,V
// PORTS
//  clk         in   1  rising-edge clock
//  reset_n     in   1  async active-low reset
//  Cond        in   4  IR[31:28]
//  Op          in   2  IR[27:26]: 00=DP, 01=MEM, 10=B, 11=unimplemented
//  Funct       in   6  IR[25:20]: [5]=I, [4:1]=cmd, [0]=S (DP) or L (MEM)
//  Rd          in   4  IR[15:12]
//  ALUFlags    in   4  NZCV from the ALU, current cycle
//  mem_ready   in   1  memory done (present only with MEM_READY_EN)
//  PCWrite     out  1  PC load
//  IRWrite     out  1  IR load
//  RegWrite    out  1  register-file write
//  MemWrite    out  1  memory write
//  AdrSrc      out  1  0=PC, 1=ALUOut
//  ALUSrcA     out  1  0=RD1, 1=PC
//  ALUSrcB     out  2  00=RD2, 01=ExtImm, 10=const 4
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
//  ImmSrc      out  2  = Op
//  RegSrc      out  2  {Op==10, Op==01}
//  state_o     out  4  current state, for debug
// BEHAVIOUR
//  Reset: state=FETCH, Flags=0000. While reset_n=0, PCWrite, IRWrite, RegWrite and MemWrite are forced 0.
//   Reset asserted mid-instruction aborts the instruction with no further writes.
//  Next-state transitions:
//   FETCH->DECODE
//   DECODE: Op00 & Funct[5]=0 -> EXECR; Op00 & Funct[5]=1 -> EXECI; Op01 -> MEMADR; Op10 -> BRANCH; Op11 -> FETCH (NOP)
//   MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR
//   MEMRD->MEMWB; MEMWB->FETCH; MEMWR->FETCH
//   EXECR/EXECI->ALUWB; ALUWB->FETCH; BRANCH->FETCH
//  Latency in cycles: B=3, STR=4, DP=4, LDR=5, Op11=2.
//  Per-state outputs (unlisted outputs are 0):
//   FETCH:   IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10
//   DECODE:  ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (R15=PC+8)
//   MEMADR:  ALUSrcA=0, ALUSrcB=01, ADD
//   MEMRD:   AdrSrc=1
//   MEMWB:   ResultSrc=01, RegWrite=CondEx
//   MEMWR:   AdrSrc=1, MemWrite=CondEx
//   EXECR:   ALUSrcB=00, ALU op from cmd
//   EXECI:   ALUSrcB=01, ALU op from cmd
//   ALUWB:   ResultSrc=00, RegWrite=CondEx & ~NoWrite
//   BRANCH:  ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx
//  Writes to Rd=15: in MEMWB/ALUWB, PCWrite=CondEx and RegWrite=0.
//  cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB with NoWrite=1).
//   Any other cmd: ADD with NoWrite=1 and no flag write.
//  Flag update: in EXECR/EXECI only, when S=1 (CMP always) and CondEx=1.
//   NZ <= ALUFlags[3:2] for all ops; CV <= ALUFlags[1:0] for ADD/SUB/CMP only.
//   The flag register is written on the clock edge leaving the EXEC state.
//  CondEx (combinational, on registered Flags):
//   EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z;
//   GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); 1110 and 1111 -> 1.
// CONFIGURATION
//  MEM_READY_EN defined: FETCH, MEMRD and MEMWR hold state until mem_ready=1.
//   While held, IRWrite, PCWrite and MemWrite are 0; they assert for exactly the one cycle in which mem_ready=1.
//  MEM_READY_EN undefined: the mem_ready port is absent and every state lasts 1 cycle.
// STRUCTURE
//  Package arm_ctrl_pkg: state enum (FETCH..BRANCH), ALUControl codes, cmd codes, cond codes, NZCV bit indices.
//  Sub-module cond_check: Cond, Flags -> CondEx, purely combinational.
// TESTING
//  Reset low, then ADD R1 (Op00, Funct 001000, Cond 1110): states F,D,EXECR,ALUWB; RegWrite=1 in cycle 4 only.
//  SUBS imm (Funct 100101), ALUFlags=0100: Z=1 after EXECI; next instr with Cond EQ writes, NE gives RegWrite=0.
//  LDR (Op01, Funct 000001): 5 states; ResultSrc=01 and RegWrite=1 in MEMWB. STR: MemWrite=1 in MEMWR, 4 cycles.
//  B with Cond NE and Z=1: BRANCH reached, PCWrite=0; with Z=0, PCWrite=1.
//  Op=11, Funct=111111: DECODE->FETCH with no write enable asserted at any point.
//  ALUWB with Rd=1111: PCWrite=1, RegWrite=0. Reset_n low during MEMWR: MemWrite=0 and state=FETCH.
//  MEM_READY_EN, mem_ready low for 3 cycles in FETCH: IRWrite pulses once, in the cycle mem_ready=1.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-like control unit.
// States, ALU control codes, DP cmd codes, condition codes and NZCV bit positions.
package arm_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned FLAG_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExecR  = 4'd6,
      StExecI  = 4'd7,
      StAluWb  = 4'd8,
      StBranch = 4'd9
   } state_e;

   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluOrr = 2'b11;

   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdOrr = 4'b1100;
   localparam logic [3:0] CmdCmp = 4'b1010;

   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondCs = 4'b0010;
   localparam logic [3:0] CondCc = 4'b0011;
   localparam logic [3:0] CondMi = 4'b0100;
   localparam logic [3:0] CondPl = 4'b0101;
   localparam logic [3:0] CondVs = 4'b0110;
   localparam logic [3:0] CondVc = 4'b0111;
   localparam logic [3:0] CondHi = 4'b1000;
   localparam logic [3:0] CondLs = 4'b1001;
   localparam logic [3:0] CondGe = 4'b1010;
   localparam logic [3:0] CondLt = 4'b1011;
   localparam logic [3:0] CondGt = 4'b1100;
   localparam logic [3:0] CondLe = 4'b1101;
   localparam logic [3:0] CondAl = 4'b1110;

   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the IR/datapath and the control FSM. The mem_ready handshake
// exists only when MEM_READY_EN is defined.
interface multicycle_controller_if;
   import arm_ctrl_pkg::*;

   logic [3:0]         Cond;
   logic [1:0]         Op;
   logic [5:0]         Funct;
   logic [3:0]         Rd;
   logic [FLAG_W-1:0]  ALUFlags;
`ifdef MEM_READY_EN
   logic               mem_ready;
`endif
   logic               PCWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic               MemWrite;
   logic               AdrSrc;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUControl;
   logic [1:0]         ImmSrc;
   logic [1:0]         RegSrc;
   logic [STATE_W-1:0] state_o;

   modport master (
`ifdef MEM_READY_EN
      input  mem_ready,
`endif
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
      output ResultSrc, ALUControl, ImmSrc, RegSrc, state_o
   );

   modport slave (
`ifdef MEM_READY_EN
      output mem_ready,
`endif
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
      input  ResultSrc, ALUControl, ImmSrc, RegSrc, state_o
   );

endinterface

// File: rtl/cond_check.sv
// Evaluates the ARM condition field against the registered NZCV flags.
module cond_check import arm_ctrl_pkg::*; (
   input  logic [3:0]        cond_i,
   input  logic [FLAG_W-1:0] flags_i,
   output logic              cond_ex_o
);

   logic n, z, c, v;

   assign n = flags_i[FlagN];
   assign z = flags_i[FlagZ];
   assign c = flags_i[FlagC];
   assign v = flags_i[FlagV];

   always_comb begin
      cond_ex_o = 1'b1;
      case (cond_i)
         CondEq:  cond_ex_o = z;
         CondNe:  cond_ex_o = ~z;
         CondCs:  cond_ex_o = c;
         CondCc:  cond_ex_o = ~c;
         CondMi:  cond_ex_o = n;
         CondPl:  cond_ex_o = ~n;
         CondVs:  cond_ex_o = v;
         CondVc:  cond_ex_o = ~v;
         CondHi:  cond_ex_o = c & ~z;
         CondLs:  cond_ex_o = ~c | z;
         CondGe:  cond_ex_o = (n == v);
         CondLt:  cond_ex_o = (n != v);
         CondGt:  cond_ex_o = ~z & (n == v);
         CondLe:  cond_ex_o = z | (n != v);
         default: cond_ex_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle ARM-like CPU: sequences ALU, memory and register file.
// Optional MEM_READY_EN makes FETCH, MEMRD and MEMWR wait for mem_ready.
module multicycle_controller import arm_ctrl_pkg::*; (
   input  logic                    clk,
   input  logic                    reset_n,
   multicycle_controller_if.master bus
);

   state_e            state_q, state_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              cond_ex, mem_ok, rd_is_pc, s_bit;
   logic [3:0]        cmd;
   logic [1:0]        alu_op;
   logic              cmd_known, no_write, arith, is_cmp;
   logic              pc_write, ir_write, reg_write, mem_write, wb_write;

   assign cmd      = bus.Funct[4:1];
   assign s_bit    = bus.Funct[0];
   assign rd_is_pc = (bus.Rd == 4'hF);

`ifdef MEM_READY_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   cond_check u_cond_check (
      .cond_i    (bus.Cond),
      .flags_i   (flags_q),
      .cond_ex_o (cond_ex)
   );

   always_comb begin
      alu_op    = AluAdd;
      cmd_known = 1'b1;
      no_write  = 1'b0;
      arith     = 1'b1;
      is_cmp    = 1'b0;
      case (cmd)
         CmdAdd: alu_op = AluAdd;
         CmdSub: alu_op = AluSub;
         CmdAnd: begin alu_op = AluAnd; arith = 1'b0; end
         CmdOrr: begin alu_op = AluOrr; arith = 1'b0; end
         CmdCmp: begin alu_op = AluSub; no_write = 1'b1; is_cmp = 1'b1; end
         default: begin
            cmd_known = 1'b0;
            no_write  = 1'b1;
            arith     = 1'b0;
         end
      endcase
   end

   // Logical ops only refresh NZ; unknown cmds never touch the flags.
   always_comb begin
      flags_d = flags_q;
      if ((state_q == StExecR || state_q == StExecI) && cond_ex && cmd_known &&
          (s_bit || is_cmp)) begin
         flags_d[FlagN] = bus.ALUFlags[FlagN];
         flags_d[FlagZ] = bus.ALUFlags[FlagZ];
         if (arith) begin
            flags_d[FlagC] = bus.ALUFlags[FlagC];
            flags_d[FlagV] = bus.ALUFlags[FlagV];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_write       = 1'b0;
      ir_write       = 1'b0;
      reg_write      = 1'b0;
      mem_write      = 1'b0;
      wb_write       = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'b00;
      bus.ResultSrc  = 2'b00;
      bus.ALUControl = AluAdd;
      case (state_q)
         StFetch: begin
            ir_write      = mem_ok;
            pc_write      = mem_ok;
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            if (mem_ok) state_d = StDecode;
         end
         StDecode: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            case (bus.Op)
               2'b00:   state_d = bus.Funct[5] ? StExecI : StExecR;
               2'b01:   state_d = StMemAdr;
               2'b10:   state_d = StBranch;
               default: state_d = StFetch;
            endcase
         end
         StMemAdr: begin
            bus.ALUSrcB = 2'b01;
            state_d     = bus.Funct[0] ? StMemRd : StMemWr;
         end
         StMemRd: begin
            bus.AdrSrc = 1'b1;
            if (mem_ok) state_d = StMemWb;
         end
         StMemWb: begin
            bus.ResultSrc = 2'b01;
            wb_write      = cond_ex;
            state_d       = StFetch;
         end
         StMemWr: begin
            bus.AdrSrc = 1'b1;
            mem_write  = cond_ex & mem_ok;
            if (mem_ok) state_d = StFetch;
         end
         StExecR: begin
            bus.ALUControl = alu_op;
            state_d        = StAluWb;
         end
         StExecI: begin
            bus.ALUSrcB    = 2'b01;
            bus.ALUControl = alu_op;
            state_d        = StAluWb;
         end
         StAluWb: begin
            wb_write = cond_ex & ~no_write;
            state_d  = StFetch;
         end
         StBranch: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            pc_write      = cond_ex;
            state_d       = StFetch;
         end
         default: state_d = StFetch;
      endcase
      // A writeback to R15 becomes a PC load instead of a register write.
      if (rd_is_pc) pc_write = pc_write | wb_write;
      else          reg_write = wb_write;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   assign bus.PCWrite  = pc_write & reset_n;
   assign bus.IRWrite  = ir_write & reset_n;
   assign bus.RegWrite = reg_write & reset_n;
   assign bus.MemWrite = mem_write & reset_n;
   assign bus.ImmSrc   = bus.Op;
   assign bus.RegSrc   = {bus.Op == 2'b10, bus.Op == 2'b01};
   assign bus.state_o  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction state sequences from instruction class, per-state
// outputs from the control table, NZCV/condition model in plain arithmetic.
module tb_multicycle_controller;
   import arm_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, rw, mw, adr, srca;
      logic [1:0] srcb, res, aluc;
   } exp_t;

   typedef struct packed {
      logic       known;
      logic [1:0] alu;
      logic       writes;
      logic       arith;
   } cmd_t;

   logic clk, reset_n;
   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   exp_t  exp_cur;
   logic  exp_valid = 1'b0;
   logic  exp_rst   = 1'b0;
   logic [1:0] cur_op;
   logic  fn, fz, fc, fv;
   int    ncyc, fetch_stall;
   logic  stall_en;
   logic [31:0] rw_m, pcw_m, mw_m, irw_m;
   logic [1:0]  last_res;
   logic [3:0]  last_state;
   logic [3:0]  cmd_tab [5];

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   function automatic logic cond_m(input logic [3:0] c);
      logic b;
      case (c[3:1])
         3'd0: b = fz;
         3'd1: b = fc;
         3'd2: b = fn;
         3'd3: b = fv;
         3'd4: b = fc && !fz;
         3'd5: b = (fn == fv);
         3'd6: b = !fz && (fn == fv);
         default: return 1'b1;
      endcase
      return c[0] ? !b : b;
   endfunction

   function automatic cmd_t cmd_m(input logic [3:0] cmd);
      cmd_t m;
      m = '0;
      m.known = 1'b1;
      case (cmd)
         4'b0100: begin m.alu = 2'd0; m.writes = 1'b1; m.arith = 1'b1; end
         4'b0010: begin m.alu = 2'd1; m.writes = 1'b1; m.arith = 1'b1; end
         4'b0000: begin m.alu = 2'd2; m.writes = 1'b1; end
         4'b1100: begin m.alu = 2'd3; m.writes = 1'b1; end
         4'b1010: begin m.alu = 2'd1; m.arith = 1'b1; end
         default: m.known = 1'b0;
      endcase
      return m;
   endfunction

   function automatic exp_t model_out(input logic [3:0] s, input logic [5:0] f,
                                      input logic [3:0] rd, input logic ce, input logic rdy);
      exp_t e;
      cmd_t m;
      logic wr;
      e = '0;
      e.st = s;
      wr = 1'b0;
      m = cmd_m(f[4:1]);
      case (s)
         StFetch:  begin e.irw = rdy; e.pcw = rdy; e.srca = 1; e.srcb = 2; e.res = 2; end
         StDecode: begin e.srca = 1; e.srcb = 2; e.res = 2; end
         StMemAdr: e.srcb = 1;
         StMemRd:  e.adr = 1;
         StMemWb:  begin e.res = 1; wr = ce; end
         StMemWr:  begin e.adr = 1; e.mw = ce && rdy; end
         StExecR:  e.aluc = m.alu;
         StExecI:  begin e.srcb = 1; e.aluc = m.alu; end
         StAluWb:  wr = ce && m.writes;
         StBranch: begin e.srcb = 1; e.res = 2; e.pcw = ce; end
         default: ;
      endcase
      if (s == StMemWb || s == StAluWb) begin
         if (rd == 4'hF) e.pcw = wr;
         else            e.rw  = wr;
      end
      return e;
   endfunction

   function automatic logic pick_ready();
      if (fetch_stall > 0) begin
         fetch_stall--;
         return 1'b0;
      end
      if (stall_en) return ($urandom_range(0, 2) != 0);
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         chk("state", int'(bus.state_o), int'(exp_cur.st));
         chk("PCWrite", int'(bus.PCWrite), int'(exp_cur.pcw));
         chk("IRWrite", int'(bus.IRWrite), int'(exp_cur.irw));
         chk("RegWrite", int'(bus.RegWrite), int'(exp_cur.rw));
         chk("MemWrite", int'(bus.MemWrite), int'(exp_cur.mw));
         if (!exp_rst) begin
            chk("AdrSrc", int'(bus.AdrSrc), int'(exp_cur.adr));
            chk("ALUSrcA", int'(bus.ALUSrcA), int'(exp_cur.srca));
            chk("ALUSrcB", int'(bus.ALUSrcB), int'(exp_cur.srcb));
            chk("ResultSrc", int'(bus.ResultSrc), int'(exp_cur.res));
            chk("ALUControl", int'(bus.ALUControl), int'(exp_cur.aluc));
            chk("ImmSrc", int'(bus.ImmSrc), int'(cur_op));
            chk("RegSrc", int'(bus.RegSrc), int'({cur_op == 2'b10, cur_op == 2'b01}));
         end
      end
   end

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         reset_n = 1'b0;
         {fn, fz, fc, fv} = 4'b0000;
         exp_cur = '0;
         exp_cur.st = StFetch;
         exp_rst = 1'b1;
         exp_valid = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input int af, input int rst_at);
      logic [3:0] seq[$];
      logic [3:0] s, afd;
      logic       rdy, ce;
      cmd_t       m;
      int         k;
      seq.push_back(StFetch);
      seq.push_back(StDecode);
      case (op)
         2'b00: begin seq.push_back(funct[5] ? StExecI : StExecR); seq.push_back(StAluWb); end
         2'b01: begin
            seq.push_back(StMemAdr);
            if (funct[0]) begin seq.push_back(StMemRd); seq.push_back(StMemWb); end
            else seq.push_back(StMemWr);
         end
         2'b10: seq.push_back(StBranch);
         default: ;
      endcase
      m = cmd_m(funct[4:1]);
      k = 0;
      ncyc = 0;
      rw_m = '0; pcw_m = '0; mw_m = '0; irw_m = '0;
      while (k < seq.size()) begin
         s = seq[k];
         @(posedge clk);
         #1;
         rdy = 1'b1;
`ifdef MEM_READY_EN
         if (s == StFetch || s == StMemRd || s == StMemWr) rdy = pick_ready();
         else rdy = 1'($urandom_range(0, 1));
         bus.mem_ready = rdy;
         if (!(s == StFetch || s == StMemRd || s == StMemWr)) rdy = 1'b1;
`endif
         afd = (af < 0) ? 4'($urandom_range(0, 15)) : af[3:0];
         bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = afd;
         cur_op = op;
         ce = cond_m(cond);
         if (ncyc == rst_at) begin
            reset_n = 1'b0;
            exp_cur = '0;
            exp_cur.st = StFetch;
            exp_rst = 1'b1;
         end else begin
            reset_n = 1'b1;
            exp_rst = 1'b0;
            exp_cur = model_out(s, funct, rd, ce, rdy);
         end
         exp_valid = 1'b1;
         @(negedge clk);
         if (ncyc < 32) begin
            rw_m[ncyc] = bus.RegWrite; pcw_m[ncyc] = bus.PCWrite;
            mw_m[ncyc] = bus.MemWrite; irw_m[ncyc] = bus.IRWrite;
         end
         last_res = bus.ResultSrc;
         last_state = bus.state_o;
         if (ncyc == rst_at) begin
            {fn, fz, fc, fv} = 4'b0000;
            ncyc++;
            break;
         end
         if ((s == StExecR || s == StExecI) && ce && m.known && (funct[0] || funct[4:1] == 4'b1010))
         begin
            fn = afd[3];
            fz = afd[2];
            if (m.arith) begin fc = afd[1]; fv = afd[0]; end
         end
         ncyc++;
         if (rdy) k++;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      stall_en = 1'b0;
      fetch_stall = 0;
      {fn, fz, fc, fv} = 4'b0000;
      cur_op = 2'b00;
      bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
`ifdef MEM_READY_EN
      bus.mem_ready = 1'b0;
`endif
      cmd_tab[0] = 4'b0100; cmd_tab[1] = 4'b0010; cmd_tab[2] = 4'b0000;
      cmd_tab[3] = 4'b1100; cmd_tab[4] = 4'b1010;
      do_reset(2);

      // Flags clear after reset: BEQ must not branch.
      run_instr(4'h0, 2'b10, 6'd0, 4'd0, -1, -1);
      chk("rst_beq_pcw", int'(pcw_m), 'b001);
      run_instr(4'hE, 2'b00, 6'b001000, 4'd1, -1, -1);
      chk("add_len", ncyc, 4);
      chk("add_rw", int'(rw_m), 'b1000);
      run_instr(4'hE, 2'b00, 6'b100101, 4'd1, 4'b0100, -1);
      chk("subs_nzcv", int'({fn, fz, fc, fv}), 'b0100);
      run_instr(4'h0, 2'b00, 6'b001000, 4'd2, -1, -1);
      chk("eq_rw", int'(rw_m), 'b1000);
      run_instr(4'h1, 2'b00, 6'b001000, 4'd2, -1, -1);
      chk("ne_rw", int'(rw_m), 0);
      run_instr(4'hE, 2'b01, 6'b000001, 4'd2, -1, -1);
      chk("ldr_len", ncyc, 5);
      chk("ldr_rw", int'(rw_m), 'b10000);
      chk("ldr_res", int'(last_res), 1);
      run_instr(4'hE, 2'b01, 6'b000000, 4'd3, -1, -1);
      chk("str_len", ncyc, 4);
      chk("str_mw", int'(mw_m), 'b1000);
      run_instr(4'h1, 2'b10, 6'd0, 4'd0, -1, -1);
      chk("bne_z1_len", ncyc, 3);
      chk("bne_z1_pcw", int'(pcw_m), 'b001);
      run_instr(4'hE, 2'b00, 6'b001001, 4'd4, 4'b0000, -1);
      run_instr(4'h1, 2'b10, 6'd0, 4'd0, -1, -1);
      chk("bne_z0_pcw", int'(pcw_m), 'b101);
      run_instr(4'hE, 2'b11, 6'b111111, 4'd0, -1, -1);
      chk("op11_len", ncyc, 2);
      chk("op11_rwmw", int'(rw_m | mw_m), 0);
      chk("op11_pcw", int'(pcw_m), 'b01);
      run_instr(4'hE, 2'b00, 6'b001000, 4'hF, -1, -1);
      chk("r15_pcw", int'(pcw_m), 'b1001);
      chk("r15_rw", int'(rw_m), 0);
      run_instr(4'hE, 2'b01, 6'b000000, 4'd4, -1, 3);
      chk("rst_mw", int'(mw_m), 0);
      chk("rst_state", int'(last_state), int'(StFetch));
`ifdef MEM_READY_EN
      fetch_stall = 3;
      run_instr(4'hE, 2'b00, 6'b001000, 4'd1, -1, -1);
      chk("rdy_len", ncyc, 7);
      chk("rdy_irw", int'(irw_m), 'b1000);
      stall_en = 1'b1;
`endif

      for (int i = 0; i < 300; i++) begin
         logic [5:0] f;
         logic [3:0] c, r;
         int         ra;
         f = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) f[4:1] = cmd_tab[$urandom_range(0, 4)];
         c = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(c, 2'($urandom_range(0, 3)), f, r, -1, ra);
      end

      exp_valid = 1'b0;
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
